// File: rtl/reset_reg_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : reset_reg_v1_0
// Brief    : AXI4-Lite slave with four 32-bit software registers. Bit 0 of
//            register 0 drives RESET_S, a software-controlled reset for
//            downstream PL logic. Registers 1..3 and the remaining bits of
//            register 0 are scratch read/write storage.
// Build    : define RESETREG_AUTOCLEAR_EN to make reg0[0] self-clear after a
//            16-cycle pulse; otherwise reg0[0] is level-held.
// Revision : 1.0 - initial release
// ============================================================================
module reset_reg_v1_0 #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  output logic                              RESET_S,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);

  localparam int C_NUM_REGS = 4;
  localparam int C_STRB_W   = C_S00_AXI_DATA_WIDTH / 8;

  logic                            awready_q, awready_d;
  logic                            wready_q,  wready_d;
  logic                            aw_en_q,   aw_en_d;
  logic [1:0]                      awidx_q,   awidx_d;
  logic                            bvalid_q,  bvalid_d;
  logic                            arready_q, arready_d;
  logic [1:0]                      aridx_q,   aridx_d;
  logic                            rvalid_q,  rvalid_d;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [C_S00_AXI_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_S00_AXI_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
`ifdef RESETREG_AUTOCLEAR_EN
  // Remaining pulse cycles after the current one while reg0[0] is set.
  logic [3:0]                      pulse_cnt_q, pulse_cnt_d;
`endif

  logic wr_fire;

  // Protection bits and undecoded address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  // A write lands on the beat after acceptance, when both handshakes complete.
  assign wr_fire = awready_q & s00_axi_awvalid & wready_q & s00_axi_wvalid;

  // Next-state logic for both AXI channels and the register bank.
  always_comb begin
    awready_d = 1'b0;
    wready_d  = 1'b0;
    aw_en_d   = aw_en_q;
    awidx_d   = awidx_q;
    bvalid_d  = bvalid_q;
    arready_d = 1'b0;
    aridx_d   = aridx_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    for (int r = 0; r < C_NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
`ifdef RESETREG_AUTOCLEAR_EN
    pulse_cnt_d = pulse_cnt_q;
`endif

    // Accept address and data together; aw_en blocks new writes until the
    // previous response has been taken.
    if (!awready_q && s00_axi_awvalid && s00_axi_wvalid && aw_en_q) begin
      awready_d = 1'b1;
      wready_d  = 1'b1;
      aw_en_d   = 1'b0;
      awidx_d   = s00_axi_awaddr[3:2];
    end else if (bvalid_q && s00_axi_bready) begin
      aw_en_d   = 1'b1;
    end

    if (wr_fire) begin
      for (int b = 0; b < C_STRB_W; b++) begin
        if (s00_axi_wstrb[b]) begin
          regs_d[awidx_q][8*b +: 8] = s00_axi_wdata[8*b +: 8];
        end
      end
    end

    if (wr_fire && !bvalid_q) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

`ifdef RESETREG_AUTOCLEAR_EN
    // A write touching reg0 byte 0 (re)starts or cancels the pulse; otherwise
    // count down and drop bit 0 once the count is exhausted.
    if (wr_fire && (awidx_q == 2'd0) && s00_axi_wstrb[0]) begin
      pulse_cnt_d = s00_axi_wdata[0] ? 4'd15 : 4'd0;
    end else if (regs_q[0][0]) begin
      if (pulse_cnt_q == 4'd0) begin
        regs_d[0][0] = 1'b0;
      end else begin
        pulse_cnt_d = pulse_cnt_q - 4'd1;
      end
    end
`endif

    // Read address pulse, then data one beat later from the pre-edge registers.
    if (!arready_q && s00_axi_arvalid && !rvalid_q) begin
      arready_d = 1'b1;
      aridx_d   = s00_axi_araddr[3:2];
    end

    if (arready_q && s00_axi_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[aridx_q];
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_en_q   <= 1'b1;
      awidx_q   <= 2'd0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      aridx_q   <= 2'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int r = 0; r < C_NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
`ifdef RESETREG_AUTOCLEAR_EN
      pulse_cnt_q <= 4'd0;
`endif
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_en_q   <= aw_en_d;
      awidx_q   <= awidx_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      aridx_q   <= aridx_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      for (int r = 0; r < C_NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
`ifdef RESETREG_AUTOCLEAR_EN
      pulse_cnt_q <= pulse_cnt_d;
`endif
    end
  end

  assign RESET_S         = regs_q[0][0];
  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_reset_reg_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_reg_v1_0
// Brief    : Self-checking bench for reset_reg_v1_0: directed AXI4-Lite
//            scenarios plus randomized reads/writes against a register model.
// Build    : define RESETREG_AUTOCLEAR_EN to also check the auto-clear pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_reg_v1_0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reset_s;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register contents as software would see them.
  logic [31:0] mdl [4];

  always #5 clk = ~clk;

  reset_reg_v1_0 #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .RESET_S        (reset_s),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full write with bready held high; checks handshake timing and response.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(awready && wready) && n < 20);
    check("wr_accept", 32'(awready & wready), 32'd1);
    check("wr_reset_s_pre", 32'(reset_s), 32'(mdl[0][0]));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) mdl[addr[3:2]][8*i +: 8] = data[8*i +: 8];
    end
    check("wr_awready_pulse", 32'(awready | wready), 32'd0);
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
    check("wr_reset_s", 32'(reset_s), 32'(mdl[0][0]));
    @(posedge clk); #1;
    check("wr_bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!arready && n < 20);
    check("rd_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rd_arready_pulse", 32'(arready), 32'd0);
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rresp", 32'(rresp), 32'd0);
    data = rdata;
    @(posedge clk); #1;
    check("rd_rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int unsigned idx;
    logic [3:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] rd;
    int          hi;
    int          n;

    for (int r = 0; r < 4; r++) mdl[r] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_reset_s", 32'(reset_s), 32'd0);
    check("rst_ready", 32'({awready, wready, arready}), 32'd0);
    check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    check("rst_resp", 32'({bresp, rresp}), 32'd0);
    axi_read(4'h0, rd);
    check("rst_rd_reg0", rd, 32'h0000_0000);

    // Write set and clear at the base address (only low bits decoded)
    axi_write(4'(32'h43C0_0000), 32'd1, 4'hF);
    check("set_reset_s", 32'(reset_s), 32'd1);
    axi_write(4'(32'h43C0_0000), 32'd0, 4'hF);
    check("clr_reset_s", 32'(reset_s), 32'd0);

    // Backpressure: first write accepted, second held off until bready
    bready = 1'b0;
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'd0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!awready && n < 20);
    check("bp_first_accept", 32'(awready), 32'd1);
    @(posedge clk); #1;
    wdata = 32'd1;
    check("bp_bvalid", 32'(bvalid), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("bp_awready_blocked", 32'(awready | wready), 32'd0);
      check("bp_reset_s_hold", 32'(reset_s), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bp_bvalid_clr", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    check("bp_second_accept", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    mdl[0] = 32'd1;
    check("bp_reset_s_set", 32'(reset_s), 32'd1);
    check("bp_bvalid2", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    check("bp_bvalid2_clr", 32'(bvalid), 32'd0);
`ifdef RESETREG_AUTOCLEAR_EN
    repeat (20) @(posedge clk);
    #1 mdl[0][0] = 1'b0;
`endif

    // Byte strobes into reg2
    axi_write(4'h8, 32'hAABB_CCDD, 4'b0101);
    axi_read(4'h8, rd);
    check("strb_rd_reg2", rd, 32'h00BB_00DD);
    check("strb_reset_s", 32'(reset_s), 32'(mdl[0][0]));

    // Randomized traffic against the register model
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 3);
      a   = 4'(idx * 4 + $urandom_range(0, 3));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
`ifdef RESETREG_AUTOCLEAR_EN
      if (idx == 0) d[0] = 1'b0;
`endif
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s);
      end else begin
        axi_read(a, rd);
        check("rand_rd", rd, mdl[idx]);
      end
    end

    // Asynchronous reset between clock edges
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'hC, 32'h1234_5678, 4'hF);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_reset_s", 32'(reset_s), 32'd0);
    check("arst_valid", 32'({bvalid, rvalid, awready, arready}), 32'd0);
    #2 rst = 1'b0;
    for (int r = 0; r < 4; r++) mdl[r] = '0;
    axi_read(4'h0, rd);
    check("arst_rd_reg0", rd, 32'h0);
    axi_read(4'hC, rd);
    check("arst_rd_reg3", rd, 32'h0);

`ifdef RESETREG_AUTOCLEAR_EN
    // Auto-clear pulse: count sampled-high cycles from the write edge
    axi_write(4'h0, 32'd1, 4'hF);
    hi = 2;
    n  = 0;
    while (reset_s && n < 40) begin
      @(posedge clk); #1;
      if (reset_s) hi++;
      n++;
    end
    mdl[0][0] = 1'b0;
    check("ac_pulse_len", 32'(hi), 32'd16);
    axi_read(4'h0, rd);
    check("ac_rd_reg0", rd, 32'h0);
`else
    hi = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_reg_v1_0.md
Name: reset_reg_v1_0

Overview:
AXI4-Lite slave peripheral holding a small bank of 32-bit software registers, one bit of which drives the RESET_S output. Lets the processor assert or release a reset for downstream PL logic by writing register 0. Sits on the PS general-purpose AXI port, e.g. base 0x43C0_0000; only the low address bits are decoded.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S00_AXI_ADDR_WIDTH, 4, AXI address width; bits [3:2] select one of 4 registers; higher bits ignored.

Ports:
s00_axi_aclk  in  1  sole clock; all logic on its rising edge.
s00_axi_areset  in  1  asynchronous, active-high reset.
RESET_S  out  1  reset output; equals reg0[0].
s00_axi_awaddr / awprot / awvalid  in  ADDR_W / 3 / 1  write address channel; awprot ignored.
s00_axi_awready  out  1
s00_axi_wdata / wstrb / wvalid  in  32 / 4 / 1  write data channel.
s00_axi_wready  out  1
s00_axi_bresp / bvalid  out  2 / 1;  s00_axi_bready  in  1  write response channel.
s00_axi_araddr / arprot / arvalid  in  ADDR_W / 3 / 1;  s00_axi_arready  out  1  read address channel.
s00_axi_rdata / rresp / rvalid  out  32 / 2 / 1;  s00_axi_rready  in  1  read data channel.

Behaviour:
- Reset, asynchronous and active-high: reg0..reg3=0, RESET_S=0, awready=wready=bvalid=arready=rvalid=0, bresp=rresp=00, rdata=0, aw_en=1. Mid-transaction reset aborts it; no response is issued.
- Write acceptance: awready and wready rise together for exactly 1 cycle at the edge where awvalid&&wvalid&&aw_en&&!awready are sampled. The address is latched at that edge, and aw_en clears.
- Register write: at the next edge (awready&&awvalid&&wready&&wvalid), reg[awaddr[3:2]] is updated per byte where wstrb[i]=1. RESET_S changes right after this edge, 2 edges after the valids are first sampled.
- Response: bvalid set on the same edge as the write, bresp=00 (OKAY). bvalid holds until bvalid&&bready, then clears and aw_en sets.
- Backpressure: while bvalid is pending (bready=0), no further write is accepted. awready/wready stay 0 and registers do not change, even if awvalid/wvalid and new data persist.
- Read: arready pulses 1 cycle when arvalid&&!arready&&!rvalid; araddr is latched. rvalid rises at the next edge with rdata=reg[araddr[3:2]] and rresp=00; both hold until rready, then rvalid clears.
- Simultaneous read and write are handled independently. A read of the register being written returns the pre-write value if sampled on the same edge.
- RESET_S is a combinational copy of reg0[0]. Other bits of reg0 and reg1..reg3 are plain scratch read/write.
- Writes of wstrb=0 complete with OKAY and change nothing. All addresses within the window respond OKAY.

Optional Feature:
RESETREG_AUTOCLEAR_EN:
- Defined: writing reg0[0]=1 sets RESET_S for exactly 16 clock cycles; reg0[0] then self-clears to 0, visible on readback. Writing 1 again while the pulse is active restarts the 16-cycle count. Writing 0 ends the pulse immediately.
- Undefined: reg0[0] is level-held until software rewrites it.

Test Plan:
- Reset: assert s00_axi_areset for 1 cycle -> RESET_S=0, all valid/ready outputs 0; read reg0 after reset -> rdata=0x0000_0000.
- Write set: awaddr=0x43C0_0000, wdata=1, wstrb=0xF, awvalid=wvalid=1, bready=1 -> awready/wready 1-cycle pulse, RESET_S=1 two edges later, bvalid=1 with bresp=00.
- Write clear: same address, wdata=0 -> RESET_S returns to 0, bresp=00.
- Held bready=0: write 0, then present wdata=1 for 80 ns -> only the first write is accepted, RESET_S stays 0. Raising bready for 1 cycle lets the pending write complete and RESET_S becomes 1.
- Byte strobes and readback: write 0xAABBCCDD with wstrb=0b0101 to reg2 (addr 0x8) -> read 0x8 returns 0x00BB00DD, rresp=00; RESET_S unaffected.
- With RESETREG_AUTOCLEAR_EN: write reg0=1 -> RESET_S high for exactly 16 cycles, then 0; read reg0 returns 0.
